// File: rtl/core_axil_bridge_if.sv
// rtl/core_axil_bridge_if.sv - core memory port and AXI4-Lite master signal bundle
interface core_axil_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  mem_valid;
   logic                  mem_instr;
   logic                  mem_ready;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W/8-1:0]   mem_wstrb;
   logic [DATA_W-1:0]     mem_rdata;
   logic                  mem_err;

   logic [ADDR_W-1:0]     m_axi_awaddr;
   logic                  m_axi_awvalid;
   logic                  m_axi_awready;
   logic [DATA_W-1:0]     m_axi_wdata;
   logic [DATA_W/8-1:0]   m_axi_wstrb;
   logic                  m_axi_wvalid;
   logic                  m_axi_wready;
   logic [1:0]            m_axi_bresp;
   logic                  m_axi_bvalid;
   logic                  m_axi_bready;
   logic [ADDR_W-1:0]     m_axi_araddr;
   logic                  m_axi_arvalid;
   logic                  m_axi_arready;
   logic [DATA_W-1:0]     m_axi_rdata;
   logic [1:0]            m_axi_rresp;
   logic                  m_axi_rvalid;
   logic                  m_axi_rready;

   // Bridge side: serves the core, masters the AXI-Lite bus.
   modport master (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata, mem_err,
      output m_axi_awaddr, m_axi_awvalid, input m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid, output m_axi_bready,
      output m_axi_araddr, m_axi_arvalid, input m_axi_arready,
      input  m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready
   );

   // Environment side: the core plus the AXI-Lite slave.
   modport slave (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata, mem_err,
      input  m_axi_awaddr, m_axi_awvalid, output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
      input  m_axi_araddr, m_axi_arvalid, output m_axi_arready,
      output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready
   );
endinterface

// File: rtl/core_axil_bridge.sv
// rtl/core_axil_bridge.sv - core memory port to AXI4-Lite master bridge with bus timeout
module core_axil_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic                clk,
   input  logic                resetn,
   core_axil_bridge_if.master  bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam int TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                awvalid_q, awvalid_d;
   logic                wvalid_q, wvalid_d;
   logic                bready_q, bready_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;
   logic                mem_ready_q, mem_ready_d;
   logic                mem_err_q, mem_err_d;
   logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

   logic                timed_out;
   logic                abort;
   logic                aw_pending;
   logic                w_pending;

   // Handshake on the same edge wins over the timeout.
   assign timed_out  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));
   assign aw_pending = awvalid_q && !bus.m_axi_awready;
   assign w_pending  = wvalid_q && !bus.m_axi_wready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      mem_ready_d = 1'b0;
      mem_err_d   = 1'b0;
      mem_rdata_d = '0;
      abort       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.mem_valid && !mem_ready_q) begin
               addr_d  = bus.mem_addr;
               wdata_d = bus.mem_wdata;
               wstrb_d = bus.mem_wstrb;
               rdata_d = '0;
               err_d   = 1'b0;
               cnt_d   = '0;
               if (|bus.mem_wstrb) begin
                  state_d   = S_WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end
         S_WR: begin
            cnt_d = cnt_q + 1'b1;
            if (!aw_pending && !w_pending) begin
               awvalid_d = 1'b0;
               wvalid_d  = 1'b0;
               bready_d  = 1'b1;
               state_d   = S_WR_RESP;
            end else if (timed_out) begin
               abort = 1'b1;
            end else begin
               awvalid_d = aw_pending;
               wvalid_d  = w_pending;
            end
         end
         S_WR_RESP: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.m_axi_bvalid) begin
               bready_d = 1'b0;
               err_d    = bus.m_axi_bresp[1];
               state_d  = S_DONE;
            end else if (timed_out) begin
               abort = 1'b1;
            end
         end
         S_RD_ADDR: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_DATA;
            end else if (timed_out) begin
               abort = 1'b1;
            end
         end
         S_RD_DATA: begin
            cnt_d = cnt_q + 1'b1;
            if (bus.m_axi_rvalid) begin
               rdata_d  = bus.m_axi_rdata;
               err_d    = bus.m_axi_rresp[1];
               rready_d = 1'b0;
               state_d  = S_DONE;
            end else if (timed_out) begin
               abort = 1'b1;
            end
         end
         S_DONE: begin
            mem_ready_d = 1'b1;
            mem_err_d   = err_q;
            mem_rdata_d = rdata_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         bready_d  = 1'b0;
         arvalid_d = 1'b0;
         rready_d  = 1'b0;
         err_d     = 1'b1;
         rdata_d   = '1;
         state_d   = S_DONE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         mem_ready_q <= 1'b0;
         mem_err_q   <= 1'b0;
         mem_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         mem_ready_q <= mem_ready_d;
         mem_err_q   <= mem_err_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign bus.mem_ready     = mem_ready_q;
   assign bus.mem_err       = mem_err_q;
   assign bus.mem_rdata     = mem_rdata_q;
   assign bus.m_axi_awaddr  = addr_q;
   assign bus.m_axi_awvalid = awvalid_q;
   assign bus.m_axi_wdata   = wdata_q;
   assign bus.m_axi_wstrb   = wstrb_q;
   assign bus.m_axi_wvalid  = wvalid_q;
   assign bus.m_axi_bready  = bready_q;
   assign bus.m_axi_araddr  = addr_q;
   assign bus.m_axi_arvalid = arvalid_q;
   assign bus.m_axi_rready  = rready_q;
endmodule

// File: tb/tb_core_axil_bridge.sv
// tb/tb_core_axil_bridge.sv - directed self-checking bench for core_axil_bridge
module tb_core_axil_bridge;
   logic clk = 1'b0;
   logic resetn;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   core_axil_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   core_axil_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   task automatic idle_inputs();
      bus.mem_valid     = 1'b0;
      bus.mem_instr     = 1'b0;
      bus.mem_addr      = '0;
      bus.mem_wdata     = '0;
      bus.mem_wstrb     = '0;
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      bus.m_axi_bresp   = 2'b00;
      bus.m_axi_bvalid  = 1'b0;
      bus.m_axi_arready = 1'b0;
      bus.m_axi_rdata   = '0;
      bus.m_axi_rresp   = 2'b00;
      bus.m_axi_rvalid  = 1'b0;
   endtask

   // Drives one request against an always-ready slave and records what the core sees.
   task automatic run_zero_wait(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                                input logic [1:0] resp, input logic [31:0] rd,
                                output int lat, output int pulses, output logic err,
                                output logic [31:0] rdat, output int aw_first, output int w_first);
      bus.m_axi_awready = 1'b1;
      bus.m_axi_wready  = 1'b1;
      bus.m_axi_bvalid  = 1'b1;
      bus.m_axi_bresp   = resp;
      bus.m_axi_arready = 1'b1;
      bus.m_axi_rvalid  = 1'b1;
      bus.m_axi_rresp   = resp;
      bus.m_axi_rdata   = rd;
      bus.mem_valid     = 1'b1;
      bus.mem_addr      = addr;
      bus.mem_wdata     = wd;
      bus.mem_wstrb     = ws;
      lat = 0; pulses = 0; err = 1'b0; rdat = '0; aw_first = 0; w_first = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (bus.m_axi_awvalid && aw_first == 0) aw_first = c;
         if (bus.m_axi_wvalid && w_first == 0) w_first = c;
         if (bus.mem_ready) begin
            pulses++;
            if (lat == 0) begin
               lat  = c;
               err  = bus.mem_err;
               rdat = bus.mem_rdata;
            end
            bus.mem_valid = 1'b0;
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      idle_inputs();
      #1 resetn = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({bus.mem_ready, bus.mem_err, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
           bus.m_axi_arvalid, bus.m_axi_rready} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b exp=0000000", {bus.mem_ready, bus.mem_err, bus.m_axi_awvalid,
                  bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready});
      end
      total++;
      if ({bus.mem_rdata, bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_araddr} !== '0) begin
         bad++;
         $display("FAIL reset_data rdata=%h awaddr=%h wdata=%h exp=0", bus.mem_rdata, bus.m_axi_awaddr,
                  bus.m_axi_wdata);
      end
      resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_write_fast();
      int lat, pulses, awf, wf;
      logic err;
      logic [31:0] rdat;
      run_zero_wait(32'h1000, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0, lat, pulses, err, rdat, awf, wf);
      total++;
      if (awf !== 1 || wf !== 1) begin
         bad++; $display("FAIL wr_fast_aw_w_same_cycle aw=%0d w=%0d exp=1,1", awf, wf);
      end
      total++;
      if (lat !== 4) begin bad++; $display("FAIL wr_fast_latency got=%0d exp=4", lat); end
      total++;
      if (pulses !== 1) begin bad++; $display("FAIL wr_fast_pulses got=%0d exp=1", pulses); end
      total++;
      if (err !== 1'b0 || rdat !== 32'h0) begin
         bad++; $display("FAIL wr_fast_err_rdata err=%b rdata=%h exp=0,0", err, rdat);
      end
   endtask

   task automatic test_write_wready_delay();
      int aw_hi = 0, w_hi = 0, data_bad = 0, pulses = 0, lat = 0;
      logic err = 1'b0;
      bus.m_axi_awready = 1'b1;
      bus.m_axi_wready  = 1'b0;
      bus.m_axi_bvalid  = 1'b1;
      bus.m_axi_bresp   = 2'b00;
      bus.mem_valid = 1'b1; bus.mem_addr = 32'h1008; bus.mem_wdata = 32'h11223344; bus.mem_wstrb = 4'b0101;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (bus.m_axi_awvalid) aw_hi++;
         if (bus.m_axi_wvalid) begin
            w_hi++;
            if (bus.m_axi_wdata !== 32'h11223344 || bus.m_axi_wstrb !== 4'b0101) data_bad++;
         end
         if (bus.mem_ready) begin
            pulses++;
            if (lat == 0) begin lat = c; err = bus.mem_err; end
            bus.mem_valid = 1'b0;
         end
         if (c == 4) bus.m_axi_wready = 1'b1;
      end
      idle_inputs();
      total++;
      if (aw_hi !== 1) begin bad++; $display("FAIL wr_delay_aw_cycles got=%0d exp=1", aw_hi); end
      total++;
      if (w_hi !== 4) begin bad++; $display("FAIL wr_delay_w_cycles got=%0d exp=4", w_hi); end
      total++;
      if (data_bad !== 0) begin bad++; $display("FAIL wr_delay_data_stable bad_cycles=%0d exp=0", data_bad); end
      total++;
      if (pulses !== 1 || lat !== 7 || err !== 1'b0) begin
         bad++; $display("FAIL wr_delay_done pulses=%0d lat=%0d err=%b exp=1,7,0", pulses, lat, err);
      end
   endtask

   task automatic test_read_delay();
      int ar_hi = 0, r_hi = 0, pulses = 0, lat = 0;
      logic err = 1'b0, rready_after = 1'b1;
      logic [31:0] rdat = '0, araddr = '0;
      bus.m_axi_arready = 1'b1;
      bus.mem_valid = 1'b1; bus.mem_addr = 32'h2004; bus.mem_wstrb = 4'h0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (c == 1) araddr = bus.m_axi_araddr;
         if (c == 7) rready_after = bus.m_axi_rready;
         if (bus.m_axi_arvalid) ar_hi++;
         if (bus.m_axi_rready) r_hi++;
         if (bus.mem_ready) begin
            pulses++;
            if (lat == 0) begin lat = c; err = bus.mem_err; rdat = bus.mem_rdata; end
            bus.mem_valid = 1'b0;
         end
         if (c == 6) begin bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'h12345678; end
         if (c == 7) begin bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0; end
      end
      idle_inputs();
      total++;
      if (araddr !== 32'h2004 || ar_hi !== 1) begin
         bad++; $display("FAIL rd_delay_ar addr=%h cycles=%0d exp=00002004,1", araddr, ar_hi);
      end
      total++;
      if (r_hi !== 5 || rready_after !== 1'b0) begin
         bad++; $display("FAIL rd_delay_rready cycles=%0d after=%b exp=5,0", r_hi, rready_after);
      end
      total++;
      if (rdat !== 32'h12345678 || err !== 1'b0) begin
         bad++; $display("FAIL rd_delay_data rdata=%h err=%b exp=12345678,0", rdat, err);
      end
      total++;
      if (pulses !== 1 || lat !== 8) begin
         bad++; $display("FAIL rd_delay_done pulses=%0d lat=%0d exp=1,8", pulses, lat);
      end
   endtask

   task automatic test_read_slverr();
      int lat, pulses, awf, wf;
      logic err;
      logic [31:0] rdat;
      run_zero_wait(32'h2008, 32'h0, 4'h0, 2'b10, 32'hDEADBEEF, lat, pulses, err, rdat, awf, wf);
      total++;
      if (err !== 1'b1 || pulses !== 1 || lat !== 4) begin
         bad++; $display("FAIL rd_slverr err=%b pulses=%0d lat=%0d exp=1,1,4", err, pulses, lat);
      end
      total++;
      if (rdat !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_slverr_data got=%h exp=deadbeef", rdat); end
      run_zero_wait(32'h3000, 32'h000000A5, 4'h1, 2'b00, 32'h0, lat, pulses, err, rdat, awf, wf);
      total++;
      if (err !== 1'b0 || pulses !== 1 || lat !== 4) begin
         bad++; $display("FAIL after_slverr_write err=%b pulses=%0d lat=%0d exp=0,1,4", err, pulses, lat);
      end
   endtask

   task automatic test_timeout();
      int ar_hi = 0, pulses = 0, lat = 0;
      logic err = 1'b0;
      logic [31:0] rdat = '0;
      bus.mem_valid = 1'b1; bus.mem_addr = 32'h4000; bus.mem_wstrb = 4'h0;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (bus.m_axi_arvalid) ar_hi++;
         if (bus.mem_ready) begin
            pulses++;
            if (lat == 0) begin lat = c; err = bus.mem_err; rdat = bus.mem_rdata; end
            bus.mem_valid = 1'b0;
         end
      end
      idle_inputs();
      total++;
      if (ar_hi !== 16) begin bad++; $display("FAIL timeout_arvalid_cycles got=%0d exp=16", ar_hi); end
      total++;
      if (pulses !== 1 || lat !== 18 || err !== 1'b1) begin
         bad++; $display("FAIL timeout_done pulses=%0d lat=%0d err=%b exp=1,18,1", pulses, lat, err);
      end
      total++;
      if (rdat !== 32'hFFFFFFFF) begin bad++; $display("FAIL timeout_rdata got=%h exp=ffffffff", rdat); end
   endtask

   task automatic test_reset_mid();
      int stray = 0, lat, pulses, awf, wf;
      logic err;
      logic [31:0] rdat;
      bus.m_axi_awready = 1'b1;
      bus.m_axi_wready  = 1'b1;
      bus.mem_valid = 1'b1; bus.mem_addr = 32'h6000; bus.mem_wdata = 32'h5A5A5A5A; bus.mem_wstrb = 4'hF;
      repeat (2) @(negedge clk);
      total++;
      if (bus.m_axi_bready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_wr_resp bready=%b exp=1", bus.m_axi_bready); end
      resetn = 1'b0;
      idle_inputs();
      #1;
      total++;
      if ({bus.mem_ready, bus.mem_err, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
           bus.m_axi_arvalid, bus.m_axi_rready, bus.mem_rdata, bus.m_axi_awaddr} !== '0) begin
         bad++; $display("FAIL rst_mid_outputs bready=%b awaddr=%h exp=0,0", bus.m_axi_bready, bus.m_axi_awaddr);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.mem_ready) stray++;
         if (c == 2) resetn = 1'b1;
      end
      total++;
      if (stray !== 0) begin bad++; $display("FAIL rst_mid_stray_ready got=%0d exp=0", stray); end
      run_zero_wait(32'h5000, 32'h0, 4'h0, 2'b00, 32'h0BADF00D, lat, pulses, err, rdat, awf, wf);
      total++;
      if (rdat !== 32'h0BADF00D || err !== 1'b0 || pulses !== 1 || lat !== 4) begin
         bad++; $display("FAIL rst_mid_new_read rdata=%h err=%b pulses=%0d lat=%0d exp=0badf00d,0,1,4",
                         rdat, err, pulses, lat);
      end
   endtask

   initial begin
      test_reset();
      test_write_fast();
      test_write_wready_delay();
      test_read_delay();
      test_read_slverr();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/core_axil_bridge.md
Name: core_axil_bridge
Overview:
Parametrised bridge from the native core memory port (valid/ready, byte strobes) to an AXI4-Lite master. It supports configurable widths, full write-response and read-response channels, AW/W issued concurrently, SLVERR/DECERR reporting, and a bus timeout. It sits between the core and the AXI-Lite interconnect.
Parameters:
ADDR_W, 32, address width of mem_addr and the AXI address channels
DATA_W, 32, data width; must be 32 or 64; strobe width is DATA_W/8
TIMEOUT, 1023, maximum cycles spent waiting in any AXI wait state before the transaction is aborted; 0 disables the timeout
Ports:
clk  in  1  clock
resetn  in  1  reset; one clock, asynchronous assert, active-low
mem_valid  in  1  core request; held high until mem_ready
mem_instr  in  1  instruction fetch flag; informational only
mem_ready  out  1  one-cycle completion pulse
mem_addr  in  ADDR_W  request address
mem_wdata  in  DATA_W  write data
mem_wstrb  in  DATA_W/8  byte strobes; all zero means read
mem_rdata  out  DATA_W  read data, valid while mem_ready is high
mem_err  out  1  error flag, valid while mem_ready is high
m_axi_awaddr  out  ADDR_W  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  DATA_W  write data
m_axi_wstrb  out  DATA_W/8  write strobes
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  ADDR_W  read address
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  DATA_W  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset asserted mid-transaction drops all valids and readies immediately; no completion is returned to the core.
- All outputs are registered. FSM states: IDLE, WR (AW/W), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: a request is accepted when mem_valid is high and mem_ready is low. On acceptance, addr, wdata and wstrb are latched and the timeout counter is cleared.
  - Nonzero strobe: go to WR; awvalid and wvalid rise on the next cycle.
  - Zero strobe: go to RD_ADDR; arvalid rises on the next cycle.
- WR: awvalid and wvalid drop independently on their own handshake (valid&&ready at a clock edge). Both may complete in the same cycle, or in either order. When both have completed: go to WR_RESP with bready=1.
- WR_RESP: on bvalid, bready=0 and go to DONE with err = bresp[1].
- RD_ADDR: on arready, arvalid=0, rready=1, go to RD_DATA.
- RD_DATA: on rvalid, capture rdata into mem_rdata, err = rresp[1], rready=0, go to DONE.
- DONE: mem_ready=1 and mem_err=err for exactly one cycle, then return to IDLE. mem_rdata is 0 for writes.
- Valids are never withdrawn before their handshake, except by timeout or reset.
- Timeout: the counter increments in every non-IDLE/non-DONE state. When it reaches TIMEOUT, all valids and readies drop, the FSM goes to DONE with err=1, and mem_rdata is all-ones.
- Minimum latency, zero-wait slave: write = 4 cycles, read = 4 cycles from acceptance to mem_ready.
Test Plan:
- Write 0x1000 with data 0xCAFEF00D, strobe 0xF; awready, wready and bvalid all high -> AW/W asserted in the same cycle, bresp OKAY, single mem_ready pulse, mem_err=0, 4 cycles.
- Write with wready delayed 3 cycles behind awready -> awvalid drops first, wvalid held until wready, data and strobe unchanged, mem_ready once.
- Read 0x2004; slave returns 0x12345678 after 5-cycle rvalid delay -> mem_rdata=0x12345678 during the mem_ready pulse; rready drops after the handshake.
- Read with rresp=SLVERR (2'b10) -> mem_err=1 with the ready pulse; next request accepted normally.
- TIMEOUT=16, slave never asserts arready -> arvalid drops at cycle 16, mem_ready=1, mem_err=1, mem_rdata=all-ones.
- resetn pulled low while in WR_RESP, then released, then a new read issued -> all outputs 0 during reset, no stray mem_ready, new read completes correctly.
